// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared helpers for the multi-channel clock divider.
//   chan_w     : index width for a channel select, max(1, clog2(channels))
//   clamp_half : maps a zero half-period to 1 (a zero half-period has no meaning)
package clkdiv_pkg;

  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Operates on a 64-bit container; callers size-cast to their WIDTH.
  function automatic logic [63:0] clamp_half(input logic [63:0] h);
    return (h == 64'd0) ? 64'd1 : h;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with a glitch-free, double-buffered half-period.
// Ports:
//   clk, reset      : system clock, async active-high reset
//   en              : count enable (hold when low)
//   sync            : synchronous phase restart (count=0, out=1)
//   load, load_half : accept a new (already clamped) half-period into the pending slot
//   pend_out        : pending slot occupied
//   out, tick       : divided clock and one-cycle strobe on each toggle
module clkdiv_chan import clkdiv_pkg::*; #(
  parameter int WIDTH        = 26,
  parameter int DEFAULT_HALF = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_half,
  output logic             pend_out,
  output logic             out,
  output logic             tick
);

  logic [WIDTH-1:0] r_count, r_half, r_pend_half;
  logic             r_pend, r_out, r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_half      <= WIDTH'(DEFAULT_HALF);
      r_pend_half <= '0;
      r_pend      <= 1'b0;
      r_out       <= 1'b1;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (sync) begin
        r_count <= '0;
        r_out   <= 1'b1;
        if (r_pend) begin
          r_half <= r_pend_half;
          r_pend <= 1'b0;
        end
      end else if (en) begin
        // >= rather than ==: a value applied while disabled may be shorter
        // than the held count; wrap at once instead of running the counter round.
        if (r_count >= r_half - WIDTH'(1)) begin
          r_count <= '0;
          r_out   <= ~r_out;
          r_tick  <= 1'b1;
          if (r_pend) begin
            r_half <= r_pend_half;
            r_pend <= 1'b0;
          end
        end else begin
          r_count <= r_count + WIDTH'(1);
        end
      end else if (r_pend) begin
        // Disabled channel has no phase to protect: apply immediately.
        r_half <= r_pend_half;
        r_pend <= 1'b0;
      end
      // load only happens while the slot is empty, so it never races an apply.
      if (load) begin
        r_pend_half <= load_half;
        r_pend      <= 1'b1;
      end
    end
  end

  assign pend_out = r_pend;
  assign out      = r_out;
  assign tick     = r_tick;

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CHANNELS independent programmable clock dividers from one clock.
// Ports:
//   clk, reset          : system clock, async active-high reset
//   en[CHANNELS]        : per-channel count enable
//   sync                : restart the phase of every channel
//   cfg_valid/cfg_ready : config write handshake (ready = target slot empty)
//   cfg_chan, cfg_half  : target channel and new half-period (0 treated as 1)
//   out[CHANNELS]       : divided clocks
//   tick[CHANNELS]      : one-cycle strobe on each out toggle
module clkdiv_multi import clkdiv_pkg::*; #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 26,
  parameter int DEFAULT_HALF = 50000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           en,
  input  logic                          sync,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [chan_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]              cfg_half,
  output logic [CHANNELS-1:0]           out,
  output logic [CHANNELS-1:0]           tick
);

  localparam int CW = chan_w(CHANNELS);

  logic [CHANNELS-1:0] w_pend, w_load;
  logic [WIDTH-1:0]    w_half_c;
  logic                w_accept;

  // Out-of-range channels keep ready high so the write is swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (cfg_chan == CW'(i)) cfg_ready = ~w_pend[i];
  end

  assign w_accept = cfg_valid & cfg_ready;
  assign w_half_c = WIDTH'(clamp_half(64'(cfg_half)));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_load[g] = w_accept && (cfg_chan == CW'(g));

    clkdiv_chan #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .en        (en[g]),
      .sync      (sync),
      .load      (w_load[g]),
      .load_half (w_half_c),
      .pend_out  (w_pend[g]),
      .out       (out[g]),
      .tick      (tick[g])
    );
  end

endmodule
